// File: rtl/mips_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit.
package mips_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_SIGN = 2'b10
   } md_state_e;

   // Operation context captured at issue and held for the whole operation
   typedef struct packed {
      md_op_e op;
      logic   sign_a;
      logic   sign_b;
      logic   dz;      // divide by zero: skip iteration, result preloaded
   } md_ctx_t;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for the mul/div unit: magnitude extraction of
// the forwarded operands at issue, and sign correction of the raw
// product or {remainder, quotient} at the end of an operation.
module muldiv_signfix
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]         cap_op,
   input  logic [WIDTH-1:0]   cap_a,
   input  logic [WIDTH-1:0]   cap_b,
   output logic               cap_sa,
   output logic               cap_sb,
   output logic [WIDTH-1:0]   abs_a,
   output logic [WIDTH-1:0]   abs_b,
   input  logic [1:0]         fix_op,
   input  logic               fix_sa,
   input  logic               fix_sb,
   input  logic [2*WIDTH-1:0] fix_val,
   output logic [WIDTH-1:0]   res_hi,
   output logic [WIDTH-1:0]   res_lo
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Capture side: unsigned ops pass operands through untouched
   always_comb begin
      cap_sa = op_is_signed(cap_op) & cap_a[WIDTH-1];
      cap_sb = op_is_signed(cap_op) & cap_b[WIDTH-1];
      abs_a  = cap_sa ? -cap_a : cap_a;
      abs_b  = cap_sb ? -cap_b : cap_b;
   end

   // Result side: 2W negate for products, separate quotient/remainder fixes
   always_comb begin
      prod   = (fix_sa ^ fix_sb) ? -fix_val : fix_val;
      quo    = fix_val[WIDTH-1:0];
      rem    = fix_val[2*WIDTH-1:WIDTH];
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (op_is_div(fix_op)) begin
         res_lo = (fix_sa ^ fix_sb) ? -quo : quo;
         res_hi = fix_sa ? -rem : rem;
      end
   end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EXE stage; owns HI/LO.
// One radix-2 step per cycle (shift-add multiply, restoring divide),
// followed by a single sign-correction cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon
// as the remaining multiplier bits are zero; the accumulator is then
// realigned by a barrel shift in SIGN.
module exe_muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_e          state;
   md_ctx_t            ctx;
   logic [WIDTH-1:0]   aq;
   logic [WIDTH-1:0]   bq;
   logic [2*WIDTH:0]   acc;
   logic [CNT_W-1:0]   cnt;

   logic               cap_sa;
   logic               cap_sb;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] fix_val;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   logic               is_div;
   logic               calc_last;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH:0]   mul_next;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH:0]   div_next;

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .cap_op  (op),
      .cap_a   (opA),
      .cap_b   (opB),
      .cap_sa  (cap_sa),
      .cap_sb  (cap_sb),
      .abs_a   (abs_a),
      .abs_b   (abs_b),
      .fix_op  (ctx.op),
      .fix_sa  (ctx.sign_a),
      .fix_sb  (ctx.sign_b),
      .fix_val (fix_val),
      .res_hi  (res_hi),
      .res_lo  (res_lo)
   );

   assign is_div = op_is_div(ctx.op);

   // One radix-2 step for each operation type. acc[2W] is always zero
   // between steps, so the W+1-bit sum cannot overflow.
   always_comb begin
      mul_sum   = acc[2*WIDTH:WIDTH] + {1'b0, aq};
      mul_next  = {(acc[0] ? mul_sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:0]} >> 1;
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, bq};
      div_next  = div_trial[WIDTH] ? {1'b0, acc[2*WIDTH-2:0], 1'b0}
                                   : {1'b0, div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic [WIDTH-1:0] mul_rest;
   logic [CNT_W-1:0] shamt;

   // Multiplier bits not yet consumed after the step taken this cycle
   assign mul_rest  = bq >> (cnt + 1'b1);
   assign calc_last = (cnt == LAST) || (!is_div && (mul_rest == '0));
   // cnt steps were taken; finish the remaining zero-bit shifts at once
   assign shamt     = CNT_W'(WIDTH) - cnt;
   assign fix_val   = acc[2*WIDTH-1:0] >> shamt;
`else
   assign calc_last = (cnt == LAST);
   assign fix_val   = acc[2*WIDTH-1:0];
`endif

   // Control FSM plus HI/LO ownership; busy/done are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ctx   <= '0;
         aq    <= '0;
         bq    <= '0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  ctx.op     <= md_op_e'(op);
                  ctx.sign_a <= cap_sa;
                  ctx.sign_b <= cap_sb;
                  ctx.dz     <= op_is_div(op) && (opB == '0);
                  aq         <= abs_a;
                  bq         <= abs_b;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  if (op_is_div(op) && (opB == '0)) begin
                     // Result is known now: hi = raw dividend, lo = all ones
                     acc   <= {1'b0, opA, {WIDTH{1'b1}}};
                     state <= ST_SIGN;
                  end else if (op_is_div(op)) begin
                     acc   <= {1'b0, {WIDTH{1'b0}}, abs_a};
                     state <= ST_CALC;
                  end else begin
                     acc   <= {{(WIDTH+1){1'b0}}, abs_b};
                     state <= ST_CALC;
                  end
               end else if (!start) begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= is_div ? div_next : mul_next;
                  cnt <= cnt + 1'b1;
                  if (calc_last) state <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  done <= 1'b1;
                  if (ctx.dz) begin
                     hi <= acc[2*WIDTH-1:WIDTH];
                     lo <= acc[WIDTH-1:0];
                  end else begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: expected HI/LO queued at issue,
// compared when done pulses. Honours MULDIV_EARLY_OUT_EN for busy lengths.
module tb_exe_muldiv_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic [63:0] exp_q[$];

   exe_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference result {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin p = 64'(sa * sb); return p; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int exp_busy(input logic [1:0] o, input logic [31:0] b);
      logic [31:0] m;
      int h;
      if (o[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!o[1]) begin
         m = (o == 2'b00 && b[31]) ? -b : b;
         h = -1;
         for (int i = 0; i < 32; i++) if (m[i]) h = i;
         return (h + 2 < 2) ? 2 : h + 2;
      end
`endif
      m = b;
      h = 0;
      return 33 + h;
   endfunction

   // Scoreboard pop on every completion
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
            chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
         end
      end
   end

   // Issue one op (called at posedge+1); poke adds a start/MTHI/MTLO
   // attempt in the start cycle and in the first busy cycle.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
      int n, eb;
      exp_q.push_back(model(o, a, b));
      eb = exp_busy(o, b);
      op = o; opA = a; opB = b; start = 1'b1;
      if (poke) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBAD; end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      opA = $urandom; opB = $urandom;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (poke && n == 1) begin
            start = 1'b1; op = 2'b11; opA = 32'd9; opB = 32'd0;
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
         end
         if (poke && n == 2) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
         @(posedge clk); #1;
      end
      chk("busy_len", 64'(n), 64'(eb));
      chk("done_pulse", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int dc0;
      rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      rst = 1'b0;

      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      issue(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
      issue(2'b11, 32'd100, 32'd0, 1'b0);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      issue(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0);
      issue(2'b01, 32'h12345678, 32'd3, 1'b0);
      issue(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0);
      issue(2'b01, 32'd2, 32'h100, 1'b1);

      // MTHI/MTLO preload, then flush an in-flight MULT
      hi_we = 1'b1; wdata = 32'h11;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
      @(posedge clk); #1;
      lo_we = 1'b0;
      chk("mthi", {32'd0, hi}, 64'h11);
      chk("mtlo", {32'd0, lo}, 64'h22);
      dc0 = done_cnt;
      op = 2'b00; opA = 32'd5;
`ifdef MULDIV_EARLY_OUT_EN
      opB = 32'h40006;
`else
      opB = 32'd6;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_hi", {32'd0, hi}, 64'h11);
      chk("flush_lo", {32'd0, lo}, 64'h22);
      // flush together with start: nothing issues
      op = 2'b11; opA = 32'd9; opB = 32'd0; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_no_done", 64'(done_cnt), 64'(dc0));
      chk("flush_hold_lo", {32'd0, lo}, 64'h22);

      // Reset in CALC cycle 5
      op = 2'b01; opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_hi", {32'd0, hi}, 64'd0);
      chk("midrst_lo", {32'd0, lo}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_done", {63'd0, done}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         issue(o, a, b, 1'b0);
      end

      @(posedge clk); #1;
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EXE stage, directly downstream of the forwarding unit.
- Consumes the forwarded operands produced by the selA/selB muxes and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Raises busy so the hazard/stall logic freezes IF/ID/EXE while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue an operation this cycle (EXE holds a mult/div).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA  input  WIDTH  forwarded rs value (multiplicand/dividend).
- opB  input  WIDTH  forwarded rt value (multiplier/divisor).
- flush  input  1  squash the in-flight operation (branch/exception).
- hi_we  input  1  MTHI write.
- lo_we  input  1  MTLO write.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight; upstream must stall.
- done  output  1  one-cycle pulse; HI/LO just updated.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0. Reset mid-operation abandons it.
- States: IDLE, CALC, SIGN.
- IDLE:
  - start=1 with flush=0 latches |opA| and |opB| (absolute values for signed ops, raw for unsigned), the sign flags and op; counter=0.
  - Next state is CALC, or SIGN for a divide with opB=0.
- CALC: exactly WIDTH cycles, one radix-2 step per cycle, then SIGN.
  - Multiply: 2*WIDTH+1-bit accumulator; if acc[0] then acc[2W:W] += |A|; shift right by 1.
  - Divide: restoring. Shift {rem,quo} left; trial subtract |B|; if non-negative, keep it and set quo[0]=1.
- SIGN: one cycle; applies sign correction, writes hi/lo at the end of the cycle, then IDLE. done=1 in the next cycle only.
  - MULT: 2W product negated if signA^signB.
  - DIV: quotient negated if signA^signB; remainder takes the sign of the dividend.
  - MULT/MULTU: hi=product[2W-1:W], lo=product[W-1:0].
  - DIV/DIVU: lo=quotient, hi=remainder.
- Latency: busy is high for WIDTH+1 cycles starting the cycle after start is sampled. hi/lo hold the new value from cycle WIDTH+2 after start, the same cycle done=1.
- Divide by zero: no iteration. lo=all ones, hi=opA (raw), busy for 1 cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap).
- start while busy is ignored; upstream guarantees it is held via the stall.
- flush in CALC/SIGN: next state IDLE, hi/lo unchanged, no done.
- flush with start in the same cycle: flush wins, nothing issued.
- hi_we/lo_we are honoured only in IDLE with start=0 and take effect on the next edge. They are ignored while busy.
- hi_we/lo_we with start in the same cycle: the write is dropped; the operation issues.
- Operand values are sampled only in the start cycle; later forwarding changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, CALC exits to SIGN in the first cycle in which the remaining unshifted multiplier bits are all zero; the accumulator is aligned by a barrel shift in SIGN.
  - busy duration becomes (index of highest set bit of |B| + 2) cycles, minimum 2.
  - Results are bit-identical to the full-latency path.
  - Divide latency is unchanged.
- Not defined: fixed WIDTH+1 busy cycles for all non-zero-divisor operations.

Decomposition:
- Shared package mips_pkg holds:
  - the op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - the state encodings ST_IDLE/ST_CALC/ST_SIGN;
  - the constant WIDTH=32.
- One sub-module: muldiv_signfix. It is combinational and performs abs/negate on 32- and 64-bit values with op-dependent selection. It is used at operand capture and in SIGN.

Test Plan:
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy 33 cycles; done in cycle 34 after start.
- MULT opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU opA=100, opB=0 -> busy 1 cycle; lo=0xFFFFFFFF, hi=0x00000064; done the following cycle.
- Preload via MTHI=0x11, MTLO=0x22; MULT 5*6; assert flush in CALC cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22, done never pulses.
- Assert rst in CALC cycle 5 -> next cycle hi=lo=0, busy=0. A second start pulse while busy -> ignored; the first result is unchanged.
- With MULDIV_EARLY_OUT_EN: MULTU 0x12345678*3 -> busy 3 cycles; hi=0, lo=0x369D0368.
